// File: rtl/pc_sequencer_if.sv
// Fetch-side control bundle between the hazard/branch logic and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic              stall;
  logic [1:0]        jump_sel;
  logic              condition_branch;
  logic [XLEN-1:0]   pc_imm;
  logic [XLEN-1:0]   rs1_imm;
  logic              restart;
  logic [XLEN-1:0]   restart_pc;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc4;
  logic              flush;
  logic              halted;
  logic              misalign_err;
  logic [CNT_W-1:0]  redirect_count;

  modport master (
    output stall, jump_sel, condition_branch, pc_imm, rs1_imm, restart, restart_pc,
    input  pc, pc4, flush, halted, misalign_err, redirect_count
  );

  modport slave (
    input  stall, jump_sel, condition_branch, pc_imm, rs1_imm, restart, restart_pc,
    output pc, pc4, flush, halted, misalign_err, redirect_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Architectural PC owner: resolves JAL/JALR/branch redirects, drives a
// multi-cycle pipeline flush, and halts fetch at a terminal address.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [XLEN-1:0] END_PC_ADDR  = XLEN'(32'h13c),
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc4;
  logic [XLEN-1:0]  target_raw;
  logic             redirect_req;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             halt_pend_q, halt_pend_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pc4 = pc_q + XLEN'(4);

  // Redirect request decode: JAL beats JALR beats branch; jump_sel 11 is no jump.
  always_comb begin
    redirect_req = 1'b0;
    target_raw   = bus.pc_imm;
    if (bus.jump_sel == 2'b01) begin
      redirect_req = 1'b1;
      target_raw   = bus.pc_imm;
    end else if (bus.jump_sel == 2'b10) begin
      redirect_req = 1'b1;
      target_raw   = bus.rs1_imm & ~XLEN'(1);
    end else if (bus.condition_branch) begin
      redirect_req = 1'b1;
      target_raw   = bus.pc_imm;
    end
  end

  // Next-state, next-PC and status update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fcnt_d      = fcnt_q;
    halt_pend_d = halt_pend_q;
    mis_d       = mis_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bus.restart) begin
          pc_d = bus.restart_pc;
        end else if (redirect_req) begin
          pc_d        = {target_raw[XLEN-1:2], 2'b00};
          state_d     = FLUSH;
          fcnt_d      = FCNT_INIT;
          halt_pend_d = 1'b0;
          if (target_raw[1:0] != 2'b00) mis_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (pc4 == END_PC_ADDR) begin
          pc_d    = END_PC_ADDR;
          state_d = HALT;
        end else begin
          pc_d = pc4;
        end
      end
      FLUSH: begin
        // Reaching the end address mid-flush parks the PC there and defers
        // the HALT transition until the flush count has run out.
        if (bus.restart) begin
          pc_d        = bus.restart_pc;
          halt_pend_d = 1'b0;
        end else if (!bus.stall && !halt_pend_q) begin
          if (pc4 == END_PC_ADDR) begin
            pc_d        = END_PC_ADDR;
            halt_pend_d = 1'b1;
          end else begin
            pc_d = pc4;
          end
        end
        if (fcnt_q == 4'd0) begin
          state_d     = halt_pend_d ? HALT : RUN;
          halt_pend_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      HALT: begin
        if (bus.restart) begin
          pc_d    = bus.restart_pc;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      fcnt_q      <= '0;
      halt_pend_q <= 1'b0;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fcnt_q      <= fcnt_d;
      halt_pend_q <= halt_pend_d;
      mis_q       <= mis_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc4            = pc4;
  assign bus.flush          = (state_q == FLUSH);
  assign bus.halted         = (state_q == HALT);
  assign bus.misalign_err   = mis_q;
  assign bus.redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes the expected post-edge
// outputs, a negedge monitor pops and compares. A second instance with a
// 2-bit redirect counter shares the same inputs to check saturation.
module tb_pc_sequencer;

  logic clk;
  logic rst;

  pc_sequencer_if #(.XLEN(32), .CNT_W(16)) bus ();
  pc_sequencer_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  pc_sequencer #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_sequencer #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.stall            = bus.stall;
  assign bus2.jump_sel         = bus.jump_sel;
  assign bus2.condition_branch = bus.condition_branch;
  assign bus2.pc_imm           = bus.pc_imm;
  assign bus2.rs1_imm          = bus.rs1_imm;
  assign bus2.restart          = bus.restart;
  assign bus2.restart_pc       = bus.restart_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        ha;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] e_pc;
  logic        e_fl, e_ha, e_mis;
  logic [15:0] e_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the currently driven inputs across one edge and record what must follow.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    e.pc  = e_pc;
    e.fl  = e_fl;
    e.ha  = e_ha;
    e.mis = e_mis;
    e.cnt = e_cnt;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [1:0] sat;
      e = q.pop_front();
      sat = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      chk("pc",           bus.pc,                    e.pc);
      chk("pc4",          bus.pc4,                   e.pc + 32'd4);
      chk("flush",        {31'd0, bus.flush},        {31'd0, e.fl});
      chk("halted",       {31'd0, bus.halted},       {31'd0, e.ha});
      chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, e.mis});
      chk("redirect_cnt", {16'd0, bus.redirect_count}, {16'd0, e.cnt});
      chk("sat_cnt",      {30'd0, bus2.redirect_count}, {30'd0, sat});
      chk("sat_pc",       bus2.pc,                   e.pc);
    end
  end

  initial begin
    logic [31:0] tgt [5];
    tgt[0] = 32'h42; tgt[1] = 32'h80; tgt[2] = 32'hc0; tgt[3] = 32'h100; tgt[4] = 32'h140;

    bus.stall = 1'b0; bus.jump_sel = 2'b00; bus.condition_branch = 1'b0;
    bus.pc_imm = '0; bus.rs1_imm = '0; bus.restart = 1'b0; bus.restart_pc = '0;
    rst = 1'b1;
    e_pc = 32'h0; e_fl = 0; e_ha = 0; e_mis = 0; e_cnt = 0;

    // reset, then free-running fetch
    step(); step();
    rst = 1'b0;
    e_pc = 32'h4;  step();
    e_pc = 32'h8;  step();
    e_pc = 32'hc;  step();
    e_pc = 32'h10; step();

    // JAL at 0x10; branch pulses during flush are squashed
    bus.jump_sel = 2'b01; bus.pc_imm = 32'h40;
    e_pc = 32'h40; e_fl = 1; e_cnt = 1; step();
    bus.jump_sel = 2'b00; bus.condition_branch = 1'b1; bus.pc_imm = 32'h80;
    e_pc = 32'h44; step();
    e_pc = 32'h48; e_fl = 0; step();
    bus.condition_branch = 1'b0;
    e_pc = 32'h4c; step();

    // JALR with misaligned target
    bus.jump_sel = 2'b10; bus.rs1_imm = 32'h23;
    e_pc = 32'h20; e_fl = 1; e_cnt = 2; e_mis = 1; step();
    bus.jump_sel = 2'b00;
    e_pc = 32'h24; step();
    e_pc = 32'h28; e_fl = 0; step();

    // JALR with stall held: redirect still taken, flush length unchanged
    bus.jump_sel = 2'b10; bus.stall = 1'b1;
    e_pc = 32'h20; e_fl = 1; e_cnt = 3; step();
    bus.jump_sel = 2'b00;
    step();
    e_fl = 0; step();
    bus.stall = 1'b0;
    e_pc = 32'h24; step();

    // conditional branch
    bus.condition_branch = 1'b1; bus.pc_imm = 32'h100;
    e_pc = 32'h100; e_fl = 1; e_cnt = 4; step();
    bus.condition_branch = 1'b0;
    e_pc = 32'h104; step();
    e_pc = 32'h108; e_fl = 0; step();

    // sequential run to the end address
    for (int i = 0; i < 12; i++) begin
      e_pc = e_pc + 32'd4; step();
    end
    e_pc = 32'h13c; e_ha = 1; step();

    // HALT ignores jumps, branches and stall
    for (int i = 0; i < 10; i++) begin
      bus.jump_sel = (i % 2 == 1) ? 2'b01 : 2'b10;
      bus.condition_branch = 1'b1; bus.pc_imm = 32'h40; bus.rs1_imm = 32'h80;
      bus.stall = (i % 3 == 0);
      step();
    end
    bus.jump_sel = 2'b00; bus.condition_branch = 1'b0; bus.stall = 1'b0;
    bus.restart = 1'b1; bus.restart_pc = 32'h8;
    e_pc = 32'h8; e_ha = 0; step();
    bus.restart = 1'b0;
    e_pc = 32'hc; step();

    // stall and restart together: restart wins
    bus.stall = 1'b1; bus.restart = 1'b1; bus.restart_pc = 32'h60;
    e_pc = 32'h60; step();
    bus.restart = 1'b0;
    step();
    bus.stall = 1'b0;
    e_pc = 32'h64; step();

    // reset in the middle of a flush
    bus.jump_sel = 2'b01; bus.pc_imm = 32'h200;
    e_pc = 32'h200; e_fl = 1; e_cnt = 5; step();
    bus.jump_sel = 2'b00; rst = 1'b1;
    e_pc = 32'h0; e_fl = 0; e_mis = 0; e_cnt = 0; step();
    rst = 1'b0;
    e_pc = 32'h4; step();

    // end address reached during flush: HALT once the flush completes
    bus.jump_sel = 2'b01; bus.pc_imm = 32'h138;
    e_pc = 32'h138; e_fl = 1; e_cnt = 1; step();
    bus.jump_sel = 2'b00;
    e_pc = 32'h13c; step();
    e_fl = 0; e_ha = 1; step();
    step();

    // reset while halted
    rst = 1'b1;
    e_pc = 32'h0; e_ha = 0; e_cnt = 0; step();
    rst = 1'b0;
    e_pc = 32'h4; step();

    // restart during flush: PC reloads, flush still runs its full length
    bus.jump_sel = 2'b01; bus.pc_imm = 32'h40;
    e_pc = 32'h40; e_fl = 1; e_cnt = 1; step();
    bus.jump_sel = 2'b00; bus.restart = 1'b1; bus.restart_pc = 32'h10;
    e_pc = 32'h10; step();
    bus.restart = 1'b0;
    e_pc = 32'h14; e_fl = 0; step();

    // five more redirects: 16-bit counter reaches 6, 2-bit counter pins at 3
    for (int k = 0; k < 5; k++) begin
      bus.jump_sel = 2'b01; bus.pc_imm = tgt[k];
      e_pc = tgt[k] & ~32'h3; e_fl = 1; e_cnt = e_cnt + 16'd1;
      if (k == 0) e_mis = 1;
      step();
      bus.jump_sel = 2'b00;
      e_pc = e_pc + 32'd4; step();
      e_pc = e_pc + 32'd4; e_fl = 0; step();
    end

    // jump_sel 11 is not a jump
    bus.jump_sel = 2'b11; bus.pc_imm = 32'h300;
    e_pc = e_pc + 32'd4; step();
    bus.jump_sel = 2'b00;

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the combinational next-PC selector. It owns the architectural PC register and resolves JAL, JALR and conditional-branch redirects. It generates a multi-cycle pipeline flush, supports stalls, and latches a halted state at a configurable end address; a restart port leaves the halted state. It sits at the IF stage and feeds the instruction memory address and the IF/ID, ID/EX flush controls.

Parameters:
XLEN, 32, PC and target width in bits
RESET_PC, 32'h0, PC value loaded on reset
END_PC_ADDR, 32'h13c, terminal instruction address; reaching it halts fetch
FLUSH_CYCLES, 2, number of consecutive cycles flush is asserted after a redirect (1..15)
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold PC (hazard unit)
jump_sel  input  2  01=JAL, 10=JALR, 00/11=none
condition_branch  input  1  resolved BEQ/BNE taken
pc_imm  input  XLEN  PC+imm target (JAL/branch)
rs1_imm  input  XLEN  rs1+imm target (JALR)
restart  input  1  leave HALT, load restart_pc
restart_pc  input  XLEN  PC to load on restart
pc  output  XLEN  current fetch PC (registered)
pc4  output  XLEN  pc+4, combinational, modulo 2^XLEN
flush  output  1  registered; high while in FLUSH state
halted  output  1  registered; high in HALT state
misalign_err  output  1  sticky; target with bits[1:0]!=0 seen
redirect_count  output  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset values: pc=RESET_PC, state=RUN, flush=0, halted=0, misalign_err=0, redirect_count=0. rst has priority over every input, including mid-flush and in HALT.
- States: RUN, FLUSH (down-counter fcnt), HALT. flush=(state==FLUSH); halted=(state==HALT).
- Redirect request: jump_sel==01 or condition_branch gives target pc_imm; jump_sel==10 gives target rs1_imm with bit0 cleared. JAL beats JALR beats branch; jump_sel==11 is treated as none.
- RUN, per cycle, priority order:
  - restart: pc<=restart_pc, stay in RUN.
  - Redirect: pc<=target with bits[1:0] cleared; state<=FLUSH; fcnt<=FLUSH_CYCLES-1; redirect_count++ saturating at all-ones. A redirect overrides stall.
  - stall: pc holds.
  - pc4==END_PC_ADDR: pc<=END_PC_ADDR, state<=HALT.
  - Otherwise: pc<=pc4.
- flush rises the cycle after the redirect edge and stays high exactly FLUSH_CYCLES cycles, independent of stall.
- FLUSH:
  - jump_sel and condition_branch are ignored, because they come from squashed instructions.
  - pc advances to pc4 unless stall, and still applies the END_PC_ADDR check; a halt pending at the end of flush enters HALT after fcnt reaches 0.
  - When fcnt==0, the next state is RUN.
  - restart: pc<=restart_pc; flush finishes its count.
- HALT: pc holds at END_PC_ADDR. Redirects and stall are ignored. restart loads restart_pc, state<=RUN, and halted falls on the next edge.
- misalign_err: set on an accepted redirect whose raw target has bits[1:0]!=0; cleared only by rst. For JALR only bit1 is checked, since bit0 is cleared architecturally.
- Width: pc4 wraps modulo 2^XLEN. If END_PC_ADDR is unaligned, HALT is never reached by sequential flow.
- Stall and restart arriving together: restart wins.

Test Plan:
- rst for 2 cycles, then 3 free cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; flush=0, halted=0.
- At pc=0x10, jump_sel=01, pc_imm=0x40, FLUSH_CYCLES=2 -> next pc=0x40; flush high for exactly 2 cycles; branch pulses during those cycles are ignored; redirect_count=1.
- jump_sel=10, rs1_imm=0x23 -> pc=0x20 and misalign_err=1. The same test with stall=1 -> redirect is still taken.
- Sequential run to pc=0x138 -> next pc=0x13c, halted=1. pc stays 0x13c for 10 cycles despite jump/branch inputs. restart with restart_pc=0x8 -> pc=0x8, halted=0.
- rst asserted mid-FLUSH and again in HALT -> pc=RESET_PC and all outputs at reset values the next cycle.
- CNT_W=2 with 5 redirects -> redirect_count saturates at 3.
